// File: rtl/mux_8_to_1_rr_arb_pkg.sv
// Shared constants and types for the 8-to-1 round-robin stream merger.
package mux8_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mux8_state_t;

    // Pointer to the channel after the one just served; 3-bit arithmetic wraps 7 -> 0.
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] sel);
        return sel + 3'd1;
    endfunction

endpackage

// File: rtl/mux_8_to_1_rr_arb_if.sv
// Stream bundle for mux_8_to_1_rr_arb: eight input channels in, one merged stream out.
// Optional out_src tag present when MUX8_SRC_TAG_EN is defined.
interface mux_8_to_1_rr_arb_if
    import mux8_pkg::*;
#(
    parameter int DATA_W = 16
);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_last;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;
    logic [SEL_W-1:0]         cur_sel;
`ifdef MUX8_SRC_TAG_EN
    logic [SEL_W-1:0]         out_src;
`endif

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
`ifdef MUX8_SRC_TAG_EN
        output out_src,
`endif
        output in_ready, out_data, out_valid, out_last, busy, cur_sel
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
`ifdef MUX8_SRC_TAG_EN
        input  out_src,
`endif
        input  in_ready, out_data, out_valid, out_last, busy, cur_sel
    );

endinterface

// File: rtl/mux_8_to_1_rr_arb_rr_arb_8.sv
// Combinational 8-way round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arb_8
    import mux8_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  rr_ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any_req
);

    logic [NUM_CH-1:0] req_rot_s;
    logic              found_s;

    // Rotate requests so rr_ptr sits at bit 0; the first set bit is the distance from rr_ptr.
    always_comb begin
        req_rot_s = NUM_CH'({req, req} >> rr_ptr);
        gnt_idx   = rr_ptr;
        found_s   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found_s && req_rot_s[i]) begin
                gnt_idx = rr_ptr + SEL_W'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/mux_8_to_1_rr_arb.sv
// 8-to-1 valid/ready stream merger with round-robin grant, optional packet lock and one output register.
// Define MUX8_SRC_TAG_EN to add the registered out_src channel tag.
module mux_8_to_1_rr_arb
    import mux8_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter bit PKT_LOCK = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    mux_8_to_1_rr_arb_if.slave  bus
);

    mux8_state_t       state_r, state_nxt_s;
    logic [SEL_W-1:0]  cur_sel_r, cur_sel_nxt_s;
    logic [SEL_W-1:0]  rr_ptr_r, rr_ptr_nxt_s;
    logic [DATA_W-1:0] out_data_r, out_data_nxt_s;
    logic              out_last_r, out_last_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
`ifdef MUX8_SRC_TAG_EN
    logic [SEL_W-1:0]  out_src_r, out_src_nxt_s;
`endif

    logic [NUM_CH-1:0] in_ready_s;
    logic [DATA_W-1:0] ch_words_s [NUM_CH];
    logic [DATA_W-1:0] ch_data_s;
    logic              ch_last_s;
    logic              accept_s;
    logic [SEL_W-1:0]  gnt_idx_s;
    logic              any_req_s;

    rr_arb_8 u_rr_arb_8 (
        .req     (bus.in_valid),
        .rr_ptr  (rr_ptr_r),
        .gnt_idx (gnt_idx_s),
        .any_req (any_req_s)
    );

    // Granted channel's beat and the single-channel ready it sees.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_words_s[k] = bus.in_data[k*DATA_W +: DATA_W];
        end
        ch_data_s  = ch_words_s[cur_sel_r];
        ch_last_s  = bus.in_last[cur_sel_r];
        in_ready_s = {NUM_CH{1'b0}};
        if (state_r == LOCKED) begin
            in_ready_s[cur_sel_r] = !out_valid_r || bus.out_ready;
        end else begin
            in_ready_s = {NUM_CH{1'b0}};
        end
        accept_s = bus.in_valid[cur_sel_r] && in_ready_s[cur_sel_r];
    end

    // Grant FSM and output-stage next values.
    always_comb begin
        state_nxt_s     = state_r;
        cur_sel_nxt_s   = cur_sel_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        out_data_nxt_s  = out_data_r;
        out_last_nxt_s  = out_last_r;
        out_valid_nxt_s = out_valid_r;
`ifdef MUX8_SRC_TAG_EN
        out_src_nxt_s   = out_src_r;
`endif
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s   = LOCKED;
                    cur_sel_nxt_s = gnt_idx_s;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            LOCKED: begin
                // A stalled source keeps the grant forever; only an accepted closing beat releases it.
                if (accept_s && (ch_last_s || !PKT_LOCK)) begin
                    state_nxt_s  = IDLE;
                    rr_ptr_nxt_s = rr_next(cur_sel_r);
                end else begin
                    state_nxt_s  = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (accept_s) begin
            out_valid_nxt_s = 1'b1;
            out_data_nxt_s  = ch_data_s;
            out_last_nxt_s  = ch_last_s;
`ifdef MUX8_SRC_TAG_EN
            out_src_nxt_s   = cur_sel_r;
`endif
        end else if (bus.out_ready) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // State, grant, pointer and output-stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cur_sel_r   <= 3'd0;
            rr_ptr_r    <= 3'd0;
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef MUX8_SRC_TAG_EN
            out_src_r   <= 3'd0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            cur_sel_r   <= cur_sel_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_last_r  <= out_last_nxt_s;
            out_valid_r <= out_valid_nxt_s;
`ifdef MUX8_SRC_TAG_EN
            out_src_r   <= out_src_nxt_s;
`endif
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = (state_r == LOCKED);
    assign bus.cur_sel   = cur_sel_r;
`ifdef MUX8_SRC_TAG_EN
    assign bus.out_src   = out_src_r;
`endif

endmodule

// File: tb/tb_mux_8_to_1_rr_arb.sv
// Bench for mux_8_to_1_rr_arb: two instances (packet lock on / off) fed identical packets,
// checked every cycle against a behavioural model plus literal expectations from the test plan.
`timescale 1ns/1ps
module tb_mux_8_to_1_rr_arb;
    import mux8_pkg::*;

    localparam int DW = 16;
    localparam int ND = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_8_to_1_rr_arb_if #(.DATA_W(DW)) bus0 ();
    mux_8_to_1_rr_arb_if #(.DATA_W(DW)) bus1 ();

    mux_8_to_1_rr_arb #(.DATA_W(DW), .PKT_LOCK(1'b1)) dut0 (.clk(clk), .reset_n(rst_n), .bus(bus0));
    mux_8_to_1_rr_arb #(.DATA_W(DW), .PKT_LOCK(1'b0)) dut1 (.clk(clk), .reset_n(rst_n), .bus(bus1));

    logic [NUM_CH*DW-1:0] drv_data [ND];
    logic [NUM_CH-1:0]    drv_valid [ND];
    logic [NUM_CH-1:0]    drv_last [ND];
    logic                 drv_oready [ND];
    logic [NUM_CH-1:0]    dut_ir [ND];
    logic [DW-1:0]        dut_od [ND];
    logic                 dut_ov [ND];
    logic                 dut_ol [ND];
    logic                 dut_busy [ND];
    logic [SEL_W-1:0]     dut_sel [ND];
    logic [SEL_W-1:0]     dut_src [ND];

    assign bus0.in_data = drv_data[0];   assign bus1.in_data = drv_data[1];
    assign bus0.in_valid = drv_valid[0]; assign bus1.in_valid = drv_valid[1];
    assign bus0.in_last = drv_last[0];   assign bus1.in_last = drv_last[1];
    assign bus0.out_ready = drv_oready[0]; assign bus1.out_ready = drv_oready[1];
    assign dut_ir[0] = bus0.in_ready;    assign dut_ir[1] = bus1.in_ready;
    assign dut_od[0] = bus0.out_data;    assign dut_od[1] = bus1.out_data;
    assign dut_ov[0] = bus0.out_valid;   assign dut_ov[1] = bus1.out_valid;
    assign dut_ol[0] = bus0.out_last;    assign dut_ol[1] = bus1.out_last;
    assign dut_busy[0] = bus0.busy;      assign dut_busy[1] = bus1.busy;
    assign dut_sel[0] = bus0.cur_sel;    assign dut_sel[1] = bus1.cur_sel;
`ifdef MUX8_SRC_TAG_EN
    assign dut_src[0] = bus0.out_src;    assign dut_src[1] = bus1.out_src;
`else
    assign dut_src[0] = 3'd0;            assign dut_src[1] = 3'd0;
`endif

    // Sources: per instance, per channel, a queue of {last, data} beats.
    logic [DW:0] src_q [ND][NUM_CH][$];
    bit          en [ND][NUM_CH];

    // Behavioural model state.
    bit m_locked [ND];
    int m_sel [ND];
    int m_ptr [ND];
    bit m_ov [ND];
    bit m_ol [ND];
    int m_od [ND];
    int m_src [ND];

    int log_data [ND][$];
    int log_last [ND][$];
    int log_src [ND][$];
    int first_ov [ND];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit or_rand = 1'b0;
    bit or_val = 1'b1;
    int sent_beats = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait budget expired @cyc %0d", name, cyc);
    endtask

    task automatic clear_log();
        for (int d = 0; d < ND; d++) begin
            log_data[d].delete(); log_last[d].delete(); log_src[d].delete();
            first_ov[d] = -1;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_locked[d] = 1'b0; m_sel[d] = 0; m_ptr[d] = 0;
            m_ov[d] = 1'b0; m_ol[d] = 1'b0; m_od[d] = 0; m_src[d] = 0;
            drv_valid[d] = '0; drv_last[d] = '0; drv_data[d] = '0; drv_oready[d] = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                src_q[d][k].delete();
                en[d][k] = 1'b1;
            end
        end
    endtask

    task automatic enq(input int k, input int n, input int base);
        for (int d = 0; d < ND; d++)
            for (int b = 0; b < n; b++)
                src_q[d][k].push_back({(b == n - 1) ? 1'b1 : 1'b0, 16'(base + b)});
        sent_beats += n;
    endtask

    // One clock: check registered outputs, drive inputs, check in_ready, advance the model.
    task automatic step();
        logic [DW:0] h;
        logic [NUM_CH-1:0] m_ir;
        bit acc;
        bit found;
        int idx;
        @(negedge clk);
        cyc++;
        for (int d = 0; d < ND; d++) begin
            chk("out_valid", dut_ov[d], m_ov[d]);
            if (m_ov[d]) begin
                chk("out_data", dut_od[d], m_od[d]);
                chk("out_last", dut_ol[d], m_ol[d]);
`ifdef MUX8_SRC_TAG_EN
                chk("out_src", dut_src[d], m_src[d]);
`endif
            end
            chk("busy", dut_busy[d], m_locked[d]);
            chk("cur_sel", dut_sel[d], m_sel[d]);
            if (dut_ov[d] && first_ov[d] < 0) first_ov[d] = cyc;
            drv_oready[d] = or_rand ? ($urandom_range(0, 3) != 0) : or_val;
            for (int k = 0; k < NUM_CH; k++) begin
                if (en[d][k] && src_q[d][k].size() > 0) begin
                    h = src_q[d][k][0];
                    drv_valid[d][k] = 1'b1;
                    drv_last[d][k]  = h[DW];
                    drv_data[d][k*DW +: DW] = h[DW-1:0];
                end else begin
                    drv_valid[d][k] = 1'b0;
                    drv_last[d][k]  = 1'b0;
                end
            end
            if (dut_ov[d] && drv_oready[d]) begin
                log_data[d].push_back(int'(dut_od[d]));
                log_last[d].push_back(int'(dut_ol[d]));
                log_src[d].push_back(int'(dut_src[d]));
            end
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            m_ir = '0;
            if (m_locked[d] && (!m_ov[d] || drv_oready[d])) m_ir[m_sel[d]] = 1'b1;
            chk("in_ready", dut_ir[d], m_ir);
            acc = m_locked[d] && m_ir[m_sel[d]] && drv_valid[d][m_sel[d]];
            if (acc) begin
                h = src_q[d][m_sel[d]].pop_front();
                m_ov[d] = 1'b1; m_od[d] = int'(h[DW-1:0]); m_ol[d] = h[DW]; m_src[d] = m_sel[d];
                if (h[DW] || d == 1) begin
                    m_locked[d] = 1'b0;
                    m_ptr[d] = (m_sel[d] + 1) % NUM_CH;
                end
            end else begin
                if (drv_oready[d]) m_ov[d] = 1'b0;
                if (!m_locked[d] && drv_valid[d] != '0) begin
                    found = 1'b0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        idx = (m_ptr[d] + i) % NUM_CH;
                        if (!found && drv_valid[d][idx]) begin
                            m_sel[d] = idx;
                            found = 1'b1;
                        end
                    end
                    m_locked[d] = 1'b1;
                end
            end
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int d = 0; d < ND; d++) begin
            if (m_locked[d] || m_ov[d]) p = 1'b1;
            for (int k = 0; k < NUM_CH; k++)
                if (src_q[d][k].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        if (pending()) timeout(name);
    endtask

    task automatic chk_log(input string name, input int d, input int i, input int exp_data, input int exp_last);
        if (log_data[d].size() <= i) begin
            chk(name, -1, exp_data);
        end else begin
            chk(name, log_data[d][i], exp_data);
            chk({name, "_last"}, log_last[d][i], exp_last);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        int n;
        model_reset();
        clear_log();
        do_reset();
        #1;
        chk("rst_out_valid", dut_ov[0], 0);
        chk("rst_busy", dut_busy[0], 0);
        chk("rst_cur_sel", dut_sel[0], 0);
        chk("rst_in_ready", dut_ir[0], 0);

        // All eight channels, one-beat packets, from rr_ptr=0.
        clear_log();
        for (int k = 0; k < NUM_CH; k++) enq(k, 1, 16'h0100 + k);
        drain("all8", 200);
        for (int k = 0; k < NUM_CH; k++) begin
            chk_log("all8_order", 0, k, 16'h0100 + k, 1);
`ifdef MUX8_SRC_TAG_EN
            if (log_src[0].size() > k) chk("all8_src", log_src[0][k], k);
`endif
        end
        chk("all8_ptr_wrap", m_ptr[0], 0);

        // Channel 3, four beats, full-rate output; checks first-beat latency.
        clear_log();
        enq(3, 4, 16'h000A);
        c0 = cyc + 1;
        drain("ch3_pkt", 100);
        chk("ch3_latency", first_ov[0] - c0, 2);
        for (int b = 0; b < 4; b++) chk_log("ch3_beat", 0, b, 16'h000A + b, (b == 3) ? 1 : 0);
        chk("ch3_ptr", m_ptr[0], 4);

        // Pointer now 4: channel 5 must beat channel 0.
        clear_log();
        enq(0, 1, 16'h00F0);
        enq(5, 1, 16'h00F5);
        drain("ptr4", 100);
        chk_log("ptr4_first", 0, 0, 16'h00F5, 1);
        chk_log("ptr4_second", 0, 1, 16'h00F0, 1);

        // Backpressure mid-packet on channel 1.
        clear_log();
        enq(1, 4, 16'h0110);
        n = 0;
        while (log_data[0].size() < 1 && n < 20) begin step(); n++; end
        if (log_data[0].size() < 1) timeout("stall_start");
        or_val = 1'b0;
        repeat (5) step();
        or_val = 1'b1;
        drain("stall", 100);
        chk("stall_count", log_data[0].size(), 4);
        for (int b = 0; b < 4; b++) chk_log("stall_beat", 0, b, 16'h0110 + b, (b == 3) ? 1 : 0);
        chk("stall_count_nolock", log_data[1].size(), 4);

        // Channels 2 and 5, three beats each: interleave without lock, back-to-back with lock.
        clear_log();
        enq(2, 3, 16'h0020);
        enq(5, 3, 16'h0050);
        drain("il", 200);
        for (int i = 0; i < 6; i++) begin
            chk_log("il_nolock", 1, i, ((i % 2) == 0) ? 16'h0020 + i / 2 : 16'h0050 + i / 2, (i >= 4) ? 1 : 0);
            chk_log("il_lock", 0, i, (i < 3) ? 16'h0020 + i : 16'h0050 + i - 3, (i == 2 || i == 5) ? 1 : 0);
        end

        // Channel 6 stalls for 10 cycles mid-packet while channel 0 waits.
        clear_log();
        enq(6, 4, 16'h0060);
        n = 0;
        while (log_data[0].size() < 1 && n < 20) begin step(); n++; end
        if (log_data[0].size() < 1) timeout("drop_start");
        for (int d = 0; d < ND; d++) en[d][6] = 1'b0;
        enq(0, 1, 16'h00E0);
        repeat (10) step();
        chk("drop_hold_busy", dut_busy[0], 1);
        chk("drop_hold_sel", dut_sel[0], 6);
        for (int d = 0; d < ND; d++) en[d][6] = 1'b1;
        drain("drop", 200);
        for (int b = 0; b < 4; b++) chk_log("drop_ch6", 0, b, 16'h0060 + b, (b == 3) ? 1 : 0);
        chk_log("drop_ch0_after", 0, 4, 16'h00E0, 1);

        // Reset pulse during a channel 4 packet, then a clean restart.
        clear_log();
        enq(4, 4, 16'h0040);
        n = 0;
        while (first_ov[0] < 0 && n < 20) begin step(); n++; end
        if (first_ov[0] < 0) timeout("rst_start");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("rstmid_out_valid", dut_ov[d], 0);
            chk("rstmid_in_ready", dut_ir[d], 0);
            chk("rstmid_busy", dut_busy[d], 0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        clear_log();
        enq(4, 4, 16'h0040);
        c0 = cyc + 1;
        drain("rst_restart", 100);
        chk("restart_latency", first_ov[0] - c0, 2);
        for (int b = 0; b < 4; b++) begin
            chk_log("restart_beat", 0, b, 16'h0040 + b, (b == 3) ? 1 : 0);
`ifdef MUX8_SRC_TAG_EN
            if (log_src[0].size() > b) chk("restart_src", log_src[0][b], 4);
`endif
        end

        // Randomized traffic, backpressure and source stalls.
        clear_log();
        sent_beats = 0;
        or_rand = 1'b1;
        for (int s = 0; s < 2000; s++) begin
            if ($urandom_range(0, 5) == 0) begin
                int k = $urandom_range(0, NUM_CH - 1);
                if (src_q[0][k].size() < 8) enq(k, $urandom_range(1, 4), (k << 8) + $urandom_range(0, 255));
            end
            if ($urandom_range(0, 40) == 0) begin
                int k = $urandom_range(0, NUM_CH - 1);
                for (int d = 0; d < ND; d++) en[d][k] = !en[d][k];
            end
            step();
        end
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < NUM_CH; k++) en[d][k] = 1'b1;
        or_rand = 1'b0;
        drain("rand_drain", 2000);
        chk("rand_beats_lock", log_data[0].size(), sent_beats);
        chk("rand_beats_nolock", log_data[1].size(), sent_beats);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
